// File: rtl/el2_pkg.sv
// el2_pkg: shared types and constants for the decode trigger-hit slice.
//   EL2_TRIG_CNT        - number of hardware triggers carried down the pipe
//   el2_trig_pipe_pkt_t - per-stage packet (valid + per-trigger match) for X/R
package el2_pkg;

  localparam int unsigned EL2_TRIG_CNT = 4;

  typedef struct packed {
    logic                    valid;
    logic [EL2_TRIG_CNT-1:0] match;
  } el2_trig_pipe_pkt_t;

endpackage : el2_pkg

// File: rtl/el2_dec_trig_chain.sv
// el2_dec_trig_chain: combinational chain pairing of qualified trigger hits.
// Only built when EL2_TRIGGER_CHAIN_EN is defined.
// Ports:
//   raw        in  TRIG_CNT    qualified per-trigger match
//   trig_chain in  TRIG_CNT/2  chain bit per even trigger (pair k = 2k, 2k+1)
//   hit        out TRIG_CNT    hits after pairing
`ifdef EL2_TRIGGER_CHAIN_EN
module el2_dec_trig_chain #(
  parameter int unsigned TRIG_CNT = 4
) (
  input  logic [TRIG_CNT-1:0]   raw,
  input  logic [TRIG_CNT/2-1:0] trig_chain,
  output logic [TRIG_CNT-1:0]   hit
);

  // A chained pair only fires when both halves match, and then both bits report.
  always_comb begin
    hit = raw;
    for (int unsigned k = 0; k < TRIG_CNT/2; k++) begin
      if (trig_chain[k]) begin
        hit[2*k]   = raw[2*k] & raw[2*k+1];
        hit[2*k+1] = raw[2*k] & raw[2*k+1];
      end
    end
  end

endmodule : el2_dec_trig_chain
`endif

// File: rtl/el2_dec_trigger_hit.sv
// el2_dec_trigger_hit: carries the decode-stage i0 trigger match vector
// through X to R, qualifies it there (kill/flush/debug mode, chain pairing),
// resolves debug-halt vs breakpoint action, and keeps sticky hit status.
// Optional feature macro: EL2_TRIGGER_CHAIN_EN (chain pairing of 0/1, 2/3).
// Ports:
//   clk, rst_l                    clock, async active-low reset
//   dec_i0_trigger_match_d        raw per-trigger match of i0 in D
//   dec_i0_valid_d                i0 in D is valid
//   dec_i0_stall_d                D held; inserts a bubble into X
//   dec_x_stall                   X/R held
//   flush_lower_r                 kills X and R (and the D capture)
//   dbg_mode                      suppresses all hits
//   trig_chain                    chain bit per trigger pair
//   trig_action                   1 = debug halt, 0 = breakpoint
//   trig_hit_clr                  CSR clear of sticky bits
//   trigger_hit_r                 qualified hits of the instruction in R
//   trigger_dbg_r/ebreak_r        resolved action
//   trigger_hit_sticky            sticky hit status
module el2_dec_trigger_hit
  import el2_pkg::*;
#(
  parameter int unsigned TRIG_CNT = EL2_TRIG_CNT
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [TRIG_CNT-1:0]   dec_i0_trigger_match_d,
  input  logic                  dec_i0_valid_d,
  input  logic                  dec_i0_stall_d,
  input  logic                  dec_x_stall,
  input  logic                  flush_lower_r,
  input  logic                  dbg_mode,
  input  logic [TRIG_CNT/2-1:0] trig_chain,
  input  logic [TRIG_CNT-1:0]   trig_action,
  input  logic [TRIG_CNT-1:0]   trig_hit_clr,
  output logic [TRIG_CNT-1:0]   trigger_hit_r,
  output logic                  trigger_dbg_r,
  output logic                  trigger_ebreak_r,
  output logic [TRIG_CNT-1:0]   trigger_hit_sticky
);

  el2_trig_pipe_pkt_t    r_x;
  el2_trig_pipe_pkt_t    r_r;
  logic [TRIG_CNT-1:0]   r_sticky;

  logic [TRIG_CNT-1:0]   w_raw;
  logic [TRIG_CNT-1:0]   w_hit;
  logic                  w_dbg;

  // Flush beats every stall and also drops the D capture of the same cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_x <= '0;
      r_r <= '0;
    end else if (flush_lower_r) begin
      r_x <= '0;
      r_r <= '0;
    end else if (!dec_x_stall) begin
      r_r <= r_x;
      if (dec_i0_stall_d) begin
        r_x <= '0;
      end else begin
        r_x.valid <= dec_i0_valid_d;
        r_x.match <= dec_i0_trigger_match_d & {TRIG_CNT{dec_i0_valid_d}};
      end
    end
  end

  assign w_raw = r_r.match & {TRIG_CNT{r_r.valid & ~dbg_mode}};

`ifdef EL2_TRIGGER_CHAIN_EN
  el2_dec_trig_chain #(
    .TRIG_CNT (TRIG_CNT)
  ) u_chain (
    .raw        (w_raw),
    .trig_chain (trig_chain),
    .hit        (w_hit)
  );
`else
  logic w_unused_trig_chain;
  assign w_unused_trig_chain = ^trig_chain;
  assign w_hit               = w_raw;
`endif

  assign w_dbg            = |(w_hit & trig_action);
  assign trigger_hit_r    = w_hit;
  assign trigger_dbg_r    = w_dbg;
  assign trigger_ebreak_r = (|w_hit) & ~w_dbg;

  // Set wins over a simultaneous clear; a held R simply re-sets the bits.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~trig_hit_clr) | w_hit;
    end
  end

  assign trigger_hit_sticky = r_sticky;

endmodule : el2_dec_trigger_hit

// File: tb/tb_el2_dec_trigger_hit.sv
// Self-checking bench for el2_dec_trigger_hit: directed stimulus with
// expected outputs queued by target cycle and compared at the falling edge.
module tb_el2_dec_trigger_hit;

  logic       clk;
  logic       rst_l;
  logic [3:0] match_d;
  logic       valid_d;
  logic       stall_d;
  logic       x_stall;
  logic       flush;
  logic       dbg_mode;
  logic [1:0] trig_chain;
  logic [3:0] trig_action;
  logic [3:0] trig_hit_clr;
  logic [3:0] hit_r;
  logic       dbg_r;
  logic       ebreak_r;
  logic [3:0] sticky;

  el2_dec_trigger_hit #(
    .TRIG_CNT (4)
  ) dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .dec_i0_trigger_match_d (match_d),
    .dec_i0_valid_d         (valid_d),
    .dec_i0_stall_d         (stall_d),
    .dec_x_stall            (x_stall),
    .flush_lower_r          (flush),
    .dbg_mode               (dbg_mode),
    .trig_chain             (trig_chain),
    .trig_action            (trig_action),
    .trig_hit_clr           (trig_hit_clr),
    .trigger_hit_r          (hit_r),
    .trigger_dbg_r          (dbg_r),
    .trigger_ebreak_r       (ebreak_r),
    .trigger_hit_sticky     (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [3:0]  hit;
    logic        dbg;
    logic        ebreak;
    logic [3:0]  sticky;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned c, input string tag, input logic [3:0] h,
                           input logic d, input logic e, input logic [3:0] s);
    exp_t x;
    x.cyc = c; x.tag = tag; x.hit = h; x.dbg = d; x.ebreak = e; x.sticky = s;
    sb.push_back(x);
  endtask

  // Scoreboard consumer: compare every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_eq({sb[i].tag, ".hit"},    hit_r,    sb[i].hit);
        check_eq({sb[i].tag, ".dbg"},    dbg_r,    sb[i].dbg);
        check_eq({sb[i].tag, ".ebreak"}, ebreak_r, sb[i].ebreak);
        check_eq({sb[i].tag, ".sticky"}, sticky,   sb[i].sticky);
        sb.delete(i);
      end
    end
  end

  task automatic step(input logic [3:0] m, input logic v, input logic sd,
                      input logic xs, input logic fl);
    match_d = m; valid_d = v; stall_d = sd; x_stall = xs; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_sticky();
    trig_hit_clr = 4'b1111;
    expect_at(cyc + 1, "clr", 4'b0000, 1'b0, 1'b0, 4'b0000);
    idle(1);
    trig_hit_clr = 4'b0000;
    idle(1);
  endtask

  int unsigned c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; match_d = '0; valid_d = 1'b0; stall_d = 1'b0; x_stall = 1'b0;
    flush = 1'b0; dbg_mode = 1'b0; trig_chain = '0; trig_action = '0; trig_hit_clr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, "reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    idle(2);

    // Basic: n+2 hit, n+3 sticky
    c0 = cyc;
    expect_at(c0 + 2, "basic_r",      4'b0100, 1'b0, 1'b1, 4'b0000);
    expect_at(c0 + 3, "basic_sticky", 4'b0000, 1'b0, 1'b0, 4'b0100);
    step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    clear_sticky();

    // Chain pair 0/1
    trig_chain = 2'b01;
    c0 = cyc;
`ifdef EL2_TRIGGER_CHAIN_EN
    expect_at(c0 + 2, "chain_half", 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_at(c0 + 3, "chain_both", 4'b0011, 1'b0, 1'b1, 4'b0000);
`else
    expect_at(c0 + 2, "chain_half", 4'b0001, 1'b0, 1'b1, 4'b0000);
    expect_at(c0 + 3, "chain_both", 4'b0011, 1'b0, 1'b1, 4'b0001);
`endif
    expect_at(c0 + 4, "chain_after", 4'b0000, 1'b0, 1'b0, 4'b0011);
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    trig_chain = 2'b00;
    clear_sticky();

    // Flush kills X, and the D capture of the flush cycle
    c0 = cyc;
    expect_at(c0 + 2, "flush_x", 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_at(c0 + 3, "flush_d", 4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);

    // D stall bubbles, then X stall holding R
    c0 = cyc;
    expect_at(c0 + 2, "dstall_a", 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_at(c0 + 3, "dstall_b", 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_at(c0 + 4, "xstall_0", 4'b0010, 1'b0, 1'b1, 4'b0000);
    expect_at(c0 + 5, "xstall_1", 4'b0010, 1'b0, 1'b1, 4'b0010);
    expect_at(c0 + 6, "xstall_2", 4'b0010, 1'b0, 1'b1, 4'b0010);
    expect_at(c0 + 7, "xstall_3", 4'b0010, 1'b0, 1'b1, 4'b0010);
    expect_at(c0 + 8, "xstall_end", 4'b0000, 1'b0, 1'b0, 4'b0010);
    step(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    clear_sticky();

    // Action priority, then debug-mode suppression
    trig_action = 4'b0010;
    c0 = cyc;
    expect_at(c0 + 2, "act_dbg",    4'b0011, 1'b1, 1'b0, 4'b0000);
    expect_at(c0 + 3, "act_sticky", 4'b0000, 1'b0, 1'b0, 4'b0011);
    step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    c0 = cyc;
    expect_at(c0 + 2, "dbgmode_r",      4'b0000, 1'b0, 1'b0, 4'b0011);
    expect_at(c0 + 3, "dbgmode_sticky", 4'b0000, 1'b0, 1'b0, 4'b0011);
    step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    dbg_mode = 1'b1;
    idle(1);
    dbg_mode = 1'b0;
    idle(2);
    trig_action = 4'b0000;
    clear_sticky();

    // Sticky clear racing a new hit
    c0 = cyc;
    expect_at(c0 + 2, "stk_set",  4'b0101, 1'b0, 1'b1, 4'b0000);
    expect_at(c0 + 3, "stk_race", 4'b0001, 1'b0, 1'b1, 4'b0101);
    expect_at(c0 + 4, "stk_win",  4'b0000, 1'b0, 1'b0, 4'b0001);
    step(4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    trig_hit_clr = 4'b0101;
    idle(1);
    trig_hit_clr = 4'b0000;
    idle(2);

    // Asynchronous reset with the pipe full
    step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_hit",    hit_r,  4'b1111);
    check_eq("pre_rst_sticky", sticky, 4'b0001);
    #2;
    rst_l = 1'b0;
    #1;
    check_eq("async_rst_hit",    hit_r,    4'b0000);
    check_eq("async_rst_dbg",    dbg_r,    1'b0);
    check_eq("async_rst_ebreak", ebreak_r, 1'b0);
    check_eq("async_rst_sticky", sticky,   4'b0000);
    expect_at(cyc, "rst_hold", 4'b0000, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    expect_at(cyc,     "rst_drop0", 4'b0000, 1'b0, 1'b0, 4'b0000);
    expect_at(cyc + 1, "rst_drop1", 4'b0000, 1'b0, 1'b0, 4'b0000);
    idle(4);

    check_eq("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_el2_dec_trigger_hit
